// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage for the pipelined MIPS core.
// Holds the PC, a word-addressed instruction memory that the debug unit loads,
// and the registered IF/ID-facing output (pc, instruction, valid).
// Optional feature macro: IF_FETCH_COUNTER_EN enables the 32-bit valid-fetch
// counter on o_fetch_count; without it o_fetch_count is tied to 0.
module if_fetch_unit #(
  parameter int SIZE_PC    = 32,
  parameter int SIZE_INSTR = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int PC_STEP    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_flag_start_pc,
  input  logic                          i_flag_load_pc,
  input  logic                          i_flag_halt,
  input  logic                          i_jump,
  input  logic [SIZE_PC-1:0]            i_jump_pc,
  input  logic                          i_branch_taken,
  input  logic [SIZE_PC-1:0]            i_branch_pc,
  input  logic                          i_imem_wr_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] i_imem_wr_addr,
  input  logic [SIZE_INSTR-1:0]         i_imem_wr_data,
  output logic [SIZE_PC-1:0]            o_pc,
  output logic [SIZE_PC-1:0]            o_pc_next,
  output logic [SIZE_INSTR-1:0]         o_instruction,
  output logic                          o_valid,
  output logic                          o_halted,
  output logic [1:0]                    o_state,
  output logic [31:0]                   o_fetch_count
);

  localparam int AW    = $clog2(IMEM_DEPTH);
  localparam int ALIGN = $clog2(PC_STEP);
  localparam logic [SIZE_PC-1:0] STEP       = SIZE_PC'(PC_STEP);
  localparam logic [SIZE_PC-1:0] ALIGN_MASK = ~SIZE_PC'(PC_STEP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  // Redirect targets are truncated to a whole instruction; misalignment is not trapped.
  function automatic logic [SIZE_PC-1:0] align_target(input logic [SIZE_PC-1:0] target);
    return target & ALIGN_MASK;
  endfunction

  state_t                 state_p0;
  logic [SIZE_PC-1:0]     pc_p0;
  logic [SIZE_INSTR-1:0]  mem [IMEM_DEPTH];
  logic [AW-1:0]          rd_idx_p0;

  logic [SIZE_PC-1:0]     pc_p1;
  logic [SIZE_INSTR-1:0]  instr_p1;
  logic                   vld_p1;
  logic                   halted_p1;

  // Stage 0: PC and memory index (word address wraps modulo IMEM_DEPTH)
  assign rd_idx_p0 = pc_p0[ALIGN +: AW];

  // Debug-unit load port; writes land regardless of enable or FSM state.
  always_ff @(posedge i_clk) begin
    if (i_imem_wr_en) begin
      mem[i_imem_wr_addr] <= i_imem_wr_data;
    end
  end

  // Fetch FSM: PC update and IF/ID output register, priority halt > stall > jump > branch > fetch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_p0  <= IDLE;
      pc_p0     <= '0;
      pc_p1     <= '0;
      instr_p1  <= '0;
      vld_p1    <= 1'b0;
      halted_p1 <= 1'b0;
    end else if (i_enable) begin
      case (state_p0)
        IDLE: begin
          if (i_flag_start_pc) begin
            state_p0 <= RUN;
          end
        end
        RUN: begin
          if (i_flag_halt) begin
            state_p0  <= HALT;
            halted_p1 <= 1'b1;
            vld_p1    <= 1'b0;
            instr_p1  <= '0;
          end else if (i_flag_load_pc) begin
            // stall: PC and output register hold
          end else if (i_jump) begin
            pc_p0    <= align_target(i_jump_pc);
            vld_p1   <= 1'b0;
            instr_p1 <= '0;
          end else if (i_branch_taken) begin
            pc_p0    <= align_target(i_branch_pc);
            vld_p1   <= 1'b0;
            instr_p1 <= '0;
          end else begin
            // read-first: a same-edge write to this word is seen next time round
            instr_p1 <= mem[rd_idx_p0];
            pc_p1    <= pc_p0;
            vld_p1   <= 1'b1;
            pc_p0    <= pc_p0 + STEP;
          end
        end
        HALT: begin
          // sticky until reset
        end
        default: begin
          state_p0 <= IDLE;
        end
      endcase
    end
  end

  // Stage 1: IF/ID-facing outputs
  assign o_pc          = pc_p1;
  assign o_pc_next     = pc_p1 + STEP;
  assign o_instruction = instr_p1;
  assign o_valid       = vld_p1;
  assign o_halted      = halted_p1;
  assign o_state       = state_p0;

`ifdef IF_FETCH_COUNTER_EN
  logic        fetch_go;
  logic [31:0] cnt_p1;

  assign fetch_go = i_enable && (state_p0 == RUN) && !i_flag_halt && !i_flag_load_pc
                    && !i_jump && !i_branch_taken;

  // Count each edge that loads a valid instruction into the output register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_p1 <= '0;
    end else if (fetch_go) begin
      cnt_p1 <= cnt_p1 + 32'd1;
    end
  end

  assign o_fetch_count = cnt_p1;
`else
  assign o_fetch_count = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed steps plus a randomized phase, all
// compared against a transaction-level reference model of the fetch rules.
module tb_if_fetch_unit;

  localparam int SPC   = 32;
  localparam int SI    = 32;
  localparam int DEPTH = 16;
  localparam int STEP  = 4;
  localparam int AW    = $clog2(DEPTH);

`ifdef IF_FETCH_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           en, start, stall, halt, jmp, br, wr_en;
  logic [SPC-1:0] jpc, bpc;
  logic [AW-1:0]  wr_addr;
  logic [SI-1:0]  wr_data;
  logic [SPC-1:0] o_pc, o_pc_next;
  logic [SI-1:0]  o_instr;
  logic           o_valid, o_halted;
  logic [1:0]     o_state;
  logic [31:0]    o_cnt;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .SIZE_PC(SPC), .SIZE_INSTR(SI), .IMEM_DEPTH(DEPTH), .PC_STEP(STEP)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flag_start_pc(start),
    .i_flag_load_pc(stall), .i_flag_halt(halt), .i_jump(jmp), .i_jump_pc(jpc),
    .i_branch_taken(br), .i_branch_pc(bpc), .i_imem_wr_en(wr_en),
    .i_imem_wr_addr(wr_addr), .i_imem_wr_data(wr_data),
    .o_pc(o_pc), .o_pc_next(o_pc_next), .o_instruction(o_instr), .o_valid(o_valid),
    .o_halted(o_halted), .o_state(o_state), .o_fetch_count(o_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: byte PC, last fetched (pc, word), mode 0 idle / 1 run / 2 halt.
  int unsigned m_mem [DEPTH];
  int unsigned m_pc, m_opc, m_instr, m_cnt;
  bit          m_valid;
  int          m_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_opc = 0; m_instr = 0; m_valid = 0; m_mode = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int unsigned tgt;
    if (en) begin
      if (m_mode == 0) begin
        if (start) m_mode = 1;
      end else if (m_mode == 1) begin
        if (halt) begin
          m_mode = 2; m_valid = 0; m_instr = 0;
        end else if (stall) begin
          m_mode = 1;
        end else if (jmp || br) begin
          tgt     = jmp ? jpc : bpc;
          m_pc    = tgt - (tgt % STEP);
          m_valid = 0;
          m_instr = 0;
        end else begin
          m_opc   = m_pc;
          m_instr = m_mem[(m_pc / STEP) % DEPTH];
          m_valid = 1;
          m_pc    = m_pc + STEP;
          m_cnt   = m_cnt + 1;
        end
      end
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
  endtask

  task automatic check_all();
    int unsigned nxt;
    int unsigned cnt_exp;
    nxt     = m_opc + STEP;
    cnt_exp = CNT_EN ? m_cnt : 0;
    chk("o_pc", 64'(o_pc), 64'(m_opc));
    chk("o_pc_next", 64'(o_pc_next), 64'(nxt));
    chk("o_instruction", 64'(o_instr), 64'(m_instr));
    chk("o_valid", 64'(o_valid), 64'(m_valid));
    chk("o_halted", 64'(o_halted), 64'(m_mode == 2));
    chk("o_state", 64'(o_state), 64'(m_mode));
    chk("o_fetch_count", 64'(o_cnt), 64'(cnt_exp));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
    jmp = 1'b0; br = 1'b0; wr_en = 1'b0; jpc = '0; bpc = '0; wr_addr = '0; wr_data = '0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_pc_next", 64'(o_pc_next), 64'(STEP));
    rst = 1'b0;

    // Load program: 0x11, 0x22, 0x33 then random words
    en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i);
      wr_data = (i < 3) ? SI'((i + 1) * 32'h11) : $urandom;
      step();
    end
    wr_en = 1'b0;

    start = 1'b1; step(); start = 1'b0;
    step();
    chk("first_instr", 64'(o_instr), 64'h11);
    chk("first_pc", 64'(o_pc), 64'h0);
    step();
    chk("second_instr", 64'(o_instr), 64'h22);

    // Stall three cycles at o_pc = 4
    stall = 1'b1;
    repeat (3) step();
    chk("stall_pc", 64'(o_pc), 64'h4);
    chk("stall_instr", 64'(o_instr), 64'h22);
    stall = 1'b0;
    step();
    chk("resume_pc", 64'(o_pc), 64'h8);
    chk("resume_instr", 64'(o_instr), 64'h33);

    // Jump and branch together: jump wins, one bubble
    jmp = 1'b1; jpc = 32'h40; br = 1'b1; bpc = 32'h80;
    step();
    jmp = 1'b0; br = 1'b0;
    chk("bubble_valid", 64'(o_valid), 64'h0);
    chk("bubble_instr", 64'(o_instr), 64'h0);
    step();
    chk("jump_pc", 64'(o_pc), 64'h40);

    // Misaligned jump target is truncated
    jmp = 1'b1; jpc = 32'h6; step(); jmp = 1'b0;
    step();
    chk("misalign_pc", 64'(o_pc), 64'h4);
    chk("misalign_instr", 64'(o_instr), 64'h22);

    // Address wrap past the last word
    jmp = 1'b1; jpc = 32'h3C; step(); jmp = 1'b0;
    step();
    step();
    chk("wrap_instr", 64'(o_instr), 64'h11);

    // Disabled: everything frozen, memory still written
    en = 1'b0; wr_en = 1'b1; wr_addr = AW'(1); wr_data = 32'hA5A5;
    repeat (3) step();
    en = 1'b1;
    // Read-first: overwrite the word being fetched on the same edge
    wr_data = 32'h5A5A;
    step();
    wr_en = 1'b0;
    chk("read_first", 64'(o_instr), 64'hA5A5);

    // Branch alone, then stall together with a jump (stall wins)
    br = 1'b1; bpc = 32'h8; step(); br = 1'b0;
    step();
    stall = 1'b1; jmp = 1'b1; jpc = 32'h30; step();
    stall = 1'b0; jmp = 1'b0;
    step();

    // Randomized phase
    for (int n = 0; n < 300; n++) begin
      en      = ($urandom % 10) != 0;
      start   = ($urandom % 10) == 0;
      stall   = ($urandom % 6) == 0;
      jmp     = ($urandom % 8) == 0;
      br      = ($urandom % 8) == 0;
      jpc     = $urandom;
      bpc     = $urandom;
      wr_en   = ($urandom % 4) == 0;
      wr_addr = AW'($urandom);
      wr_data = $urandom;
      step();
    end
    en = 1'b1; start = 1'b0; stall = 1'b0; jmp = 1'b0; br = 1'b0; wr_en = 1'b0;
    step();

    // Halt is sticky; start, jump, stall ignored; memory still writable
    halt = 1'b1; step(); halt = 1'b0;
    chk("halt_state", 64'(o_state), 64'h2);
    chk("halt_flag", 64'(o_halted), 64'h1);
    chk("halt_valid", 64'(o_valid), 64'h0);
    start = 1'b1; jmp = 1'b1; jpc = 32'h20; stall = 1'b1; wr_en = 1'b1; wr_addr = AW'(3); wr_data = 32'h77;
    repeat (3) step();
    start = 1'b0; jmp = 1'b0; stall = 1'b0; wr_en = 1'b0;
    chk("halt_sticky", 64'(o_state), 64'h2);

    // Asynchronous reset in mid-cycle
    step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_reset_state", 64'(o_state), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Counter: 5 fetches, 2 stalls, 1 bubble
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    stall = 1'b1; step(); step(); stall = 1'b0;
    step();
    jmp = 1'b1; jpc = 32'h10; step(); jmp = 1'b0;
    step(); step();
    en = 1'b0; step();
    chk("fetch_count_5", 64'(o_cnt), CNT_EN ? 64'd5 : 64'd0);
    chk("word3_after_halt_write", 64'(m_mem[3]), 64'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Parametrised instruction-fetch stage for the pipelined MIPS core.
- Merges the PC register, the PC-increment path and a word-addressed instruction memory behind one IF/ID-facing output register.
- Adds features the current fetch stage lacks: jump/branch redirect with bubble insertion, a debug-unit load port for the memory, a sticky HALT state and configurable PC/instruction/memory widths.
- Sits between the debug unit (program load, start) and the IF/ID pipeline register; driven by the hazard unit (stall, halt).

Parameters:
- SIZE_PC, 32, PC width in bits.
- SIZE_INSTR, 32, instruction word width in bits.
- IMEM_DEPTH, 256, instruction memory depth in words; power of two, minimum 4.
- PC_STEP, 4, byte increment per sequential fetch; power of two.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous active-high reset.
- i_enable  input  1  stage enable from the debug unit; 0 freezes all state.
- i_flag_start_pc  input  1  single-cycle pulse, IDLE -> RUN.
- i_flag_load_pc  input  1  stall from the hazard unit; hold PC and output register.
- i_flag_halt  input  1  halt from the hazard unit; RUN -> HALT.
- i_jump  input  1  jump redirect request.
- i_jump_pc  input  SIZE_PC  jump target in bytes.
- i_branch_taken  input  1  taken-branch redirect request.
- i_branch_pc  input  SIZE_PC  branch target in bytes.
- i_imem_wr_en  input  1  memory write strobe (debug load).
- i_imem_wr_addr  input  $clog2(IMEM_DEPTH)  write word address.
- i_imem_wr_data  input  SIZE_INSTR  write data.
- o_pc  output  SIZE_PC  byte address of o_instruction.
- o_pc_next  output  SIZE_PC  o_pc + PC_STEP, for link/branch computation.
- o_instruction  output  SIZE_INSTR  fetched word; 0 (NOP) when not valid.
- o_valid  output  1  o_instruction is a real fetched instruction.
- o_halted  output  1  FSM is in HALT.
- o_state  output  2  FSM state encoding: 00 IDLE, 01 RUN, 10 HALT.
- o_fetch_count  output  32  fetched-instruction counter (see Optional Feature).

Behaviour:
- Reset (async, any state):
  - Internal PC = 0; state = IDLE.
  - o_pc = 0, o_pc_next = PC_STEP, o_instruction = 0, o_valid = 0, o_halted = 0, o_fetch_count = 0.
  - Memory contents are not cleared.
- Memory index = pc[log2(PC_STEP) +: $clog2(IMEM_DEPTH)].
  - Addresses wrap modulo IMEM_DEPTH words.
  - Target low log2(PC_STEP) bits are forced to 0 (misalignment is truncated, not trapped).
- Read latency: 1 cycle. The output register captures mem[index(pc)] and pc on the same edge that pc advances.
- i_enable = 0: no state, PC, output or counter change, in any state. Memory writes still occur.
- IDLE:
  - Memory writes accepted.
  - Output register holds the reset values.
  - i_flag_start_pc = 1 -> RUN; the first fetch happens on the next enabled edge.
- RUN (i_enable = 1), priority highest first:
  1. i_flag_halt: go to HALT; PC frozen; o_valid = 0, o_instruction = 0 from the next edge.
  2. i_flag_load_pc: PC and output register held unchanged.
  3. i_jump: pc <= i_jump_pc; output register loads a bubble (o_instruction = 0, o_valid = 0, o_pc unchanged).
  4. i_branch_taken: same as jump, using i_branch_pc.
  5. Otherwise: o_instruction <= mem[index(pc)], o_pc <= pc, o_valid <= 1, pc <= pc + PC_STEP.
     - Arithmetic is modulo 2^SIZE_PC; wrap is silent.
- Simultaneous i_jump and i_branch_taken: jump wins; the branch is dropped.
- Stall together with a redirect: the stall wins and the redirect is lost. The hazard unit must not assert both.
- HALT:
  - Sticky; left only by reset.
  - PC frozen; o_halted = 1; start, stall and redirect inputs ignored.
  - Memory writes accepted.
- Memory write in RUN:
  - Write and read of the same word on one edge: the read returns old data (read-first).
- o_pc_next is always o_pc + PC_STEP (combinational from o_pc).
- i_flag_start_pc in RUN or HALT: ignored.

Optional Feature:
- Macro: IF_FETCH_COUNTER_EN.
- Defined: a 32-bit counter increments on every edge where o_valid is loaded with 1, i.e. each valid fetch.
  - Holds in stall, bubble, HALT and IDLE.
  - Wraps at 2^32; cleared only by reset.
  - Driven on o_fetch_count.
- Not defined: no counter logic; o_fetch_count tied to 0.

Test Plan:
- Load words 0x11,0x22,0x33 at addresses 0..2, pulse start, enable -> o_instruction 0x11/0x22/0x33 on successive cycles with o_pc 0/4/8, o_valid = 1, o_pc_next 4/8/12.
- In RUN at pc = 8, assert i_jump with target 0x40 and i_branch_taken with target 0x80 together -> one bubble (o_instruction = 0, o_valid = 0), then o_pc = 0x40; the branch is ignored.
- Hold i_flag_load_pc for 3 cycles at o_pc = 4 -> o_pc = 4 and o_instruction = 0x22 unchanged; sequence resumes at o_pc = 8.
- Pulse i_flag_halt -> o_state = 10, o_halted = 1, o_valid = 0 from the next edge. Later start, jump and stall pulses cause no change. Async reset mid-cycle -> all outputs at reset values immediately, o_state = 00.
- IMEM_DEPTH = 4, PC_STEP = 4, run from pc = 0 -> pc = 16 fetches word 0 (wrap). A jump to 0x6 fetches word 1 (alignment truncation).
- With IF_FETCH_COUNTER_EN: 5 valid fetches, 2 stall cycles, 1 bubble -> o_fetch_count = 5. Without the macro -> o_fetch_count = 0 throughout.
